// File: rtl/pipeline_stage_buf_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// The stage under control takes the slave view; whoever drives both neighbours takes master.
interface pipeline_stage_buf_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipeline_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid,
// synchronous flush and a saturating back-pressure counter.
//
//   state | meaning
//   EMPTY | nothing held; in_ready=1, out_valid=0
//   ONE   | head valid in main; in_ready=1
//   TWO   | main and skid both full; in_ready=0 (only reachable with SKID=1)
module pipeline_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 flush,
  pipeline_stage_buf_if.slave  bus,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_ready, out_valid, accept, deliver;
  logic              load_main, load_skid, skid_to_main;

  // With SKID=0 readiness looks through to out_ready so a full stage can still stream.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (SKID != 0) ? (state != TWO) : ((state == EMPTY) || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign deliver   = out_valid && bus.out_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (deliver) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (deliver) begin
            state_nxt    = ONE;
            skid_to_main = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Payload survives flush; only control is scrubbed so stale entries cannot act.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main)         main_data <= bus.in_data;
      else if (skid_to_main) main_data <= skid_data;
      if (load_skid)         skid_data <= bus.in_data;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main)         main_ctrl <= bus.in_ctrl;
      else if (skid_to_main) main_ctrl <= skid_ctrl;
      if (load_skid)         skid_ctrl <= bus.in_ctrl;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (out_valid && !bus.out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = out_valid ? main_ctrl : '0;
  assign occupancy     = state;

endmodule

// File: tb/tb_pipeline_stage_buf.sv
// Bench for pipeline_stage_buf: one SKID=1/CNT_W=4 stage and one SKID=0 stage,
// both checked every cycle against a queue model of the stage.
module tb_pipeline_stage_buf;
  localparam int DW = 32;
  localparam int CW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  // index 0: SKID=1, CNT_W=4   index 1: SKID=0, CNT_W=16
  logic          s_iv[2], s_ir[2], s_fl[2];
  logic [DW-1:0] s_id[2];
  logic [CW-1:0] s_ic[2];
  logic          o_ir[2], o_v[2];
  logic [DW-1:0] o_d[2];
  logic [CW-1:0] o_c[2];
  logic [1:0]    o_occ[2];
  logic [15:0]   o_st[2];
  logic [3:0]    st1;
  logic [15:0]   st0;
  logic [1:0]    occ1, occ0;

  pipeline_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) b1 ();
  pipeline_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) b0 ();

  pipeline_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u1 (
    .CLK(CLK), .nRST(nRST), .flush(s_fl[0]), .bus(b1.slave),
    .occupancy(occ1), .stall_cnt(st1));
  pipeline_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u0 (
    .CLK(CLK), .nRST(nRST), .flush(s_fl[1]), .bus(b0.slave),
    .occupancy(occ0), .stall_cnt(st0));

  assign b1.in_valid  = s_iv[0];
  assign b1.in_data   = s_id[0];
  assign b1.in_ctrl   = s_ic[0];
  assign b1.out_ready = s_ir[0];
  assign b0.in_valid  = s_iv[1];
  assign b0.in_data   = s_id[1];
  assign b0.in_ctrl   = s_ic[1];
  assign b0.out_ready = s_ir[1];
  assign o_ir[0] = b1.in_ready;
  assign o_v[0]  = b1.out_valid;
  assign o_d[0]  = b1.out_data;
  assign o_c[0]  = b1.out_ctrl;
  assign o_occ[0] = occ1;
  assign o_st[0] = {12'd0, st1};
  assign o_ir[1] = b0.in_ready;
  assign o_v[1]  = b0.out_valid;
  assign o_d[1]  = b0.out_data;
  assign o_c[1]  = b0.out_ctrl;
  assign o_occ[1] = occ0;
  assign o_st[1] = st0;

  // reference model
  ent_t          mq[2][$];
  int            msz[2];
  logic          macc[2], mdlv[2];
  int            st_m[2];
  int            smax[2] = '{15, 65535};
  logic [DW-1:0] head[2];
  int            total = 0;
  int            passed = 0;
  int            vcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      s_iv[d] = 1'b0; s_ir[d] = 1'b1; s_fl[d] = 1'b0;
      s_id[d] = '0;   s_ic[d] = '0;
    end
  endtask

  // Compare every output against the model with the inputs currently applied.
  task automatic dc();
    logic exp_ir;
    #1;
    for (int d = 0; d < 2; d++) begin
      msz[d] = mq[d].size();
      exp_ir = (d == 0) ? (msz[d] < 2) : ((msz[d] == 0) || s_ir[d]);
      chk($sformatf("u%0d.in_ready", d), 64'(o_ir[d]), 64'(exp_ir));
      chk($sformatf("u%0d.out_valid", d), 64'(o_v[d]), 64'(msz[d] != 0));
      chk($sformatf("u%0d.out_data", d), 64'(o_d[d]),
          64'((msz[d] != 0) ? mq[d][0].d : head[d]));
      chk($sformatf("u%0d.out_ctrl", d), 64'(o_c[d]),
          64'((msz[d] != 0) ? mq[d][0].c : 8'd0));
      chk($sformatf("u%0d.occupancy", d), 64'(o_occ[d]), 64'(msz[d]));
      chk($sformatf("u%0d.stall_cnt", d), 64'(o_st[d]), 64'(st_m[d]));
      macc[d] = s_iv[d] && exp_ir;
      mdlv[d] = (msz[d] != 0) && s_ir[d];
    end
  endtask

  task automatic tick();
    ent_t e;
    @(posedge CLK);
    for (int d = 0; d < 2; d++) begin
      if (msz[d] != 0 && !s_ir[d] && st_m[d] != smax[d]) st_m[d]++;
      if (mdlv[d]) void'(mq[d].pop_front());
      if (s_fl[d]) mq[d].delete();
      else if (macc[d]) begin
        e.d = s_id[d];
        e.c = s_ic[d];
        mq[d].push_back(e);
      end
      if (mq[d].size() != 0) head[d] = mq[d][0].d;
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      st_m[d] = 0;
      head[d] = '0;
    end
    dc();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    do_reset();

    // back-to-back stream through the skid stage
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      s_iv[0] = 1'b1; s_ir[0] = 1'b1;
      s_id[0] = 32'h100 + 32'(i); s_ic[0] = 8'h80 | 8'(i);
      dc(); vcnt += int'(o_v[0]); tick();
    end
    s_iv[0] = 1'b0;
    repeat (3) begin dc(); vcnt += int'(o_v[0]); tick(); end
    chk("stream.valid_cycles", 64'(vcnt), 64'd8);
    chk("stream.stall_cnt", 64'(o_st[0]), 64'd0);

    // fill A,B under back-pressure, then release
    do_reset();
    s_ir[0] = 1'b0; s_iv[0] = 1'b1;
    s_id[0] = 32'h11; s_ic[0] = 8'h01; dc(); tick();
    s_id[0] = 32'h22; s_ic[0] = 8'h02; dc(); tick();
    s_iv[0] = 1'b0; dc();
    chk("fill.occupancy", 64'(o_occ[0]), 64'd2);
    chk("fill.in_ready", 64'(o_ir[0]), 64'd0);
    tick();
    s_ir[0] = 1'b1; dc();
    chk("drain.first", 64'(o_d[0]), 64'h11);
    tick(); dc();
    chk("drain.second", 64'(o_d[0]), 64'h22);
    chk("drain.in_ready", 64'(o_ir[0]), 64'd1);
    tick(); dc();
    chk("drain.stall_cnt", 64'(o_st[0]), 64'd2);
    tick();

    // flush while full with C offered
    s_ir[0] = 1'b0; s_iv[0] = 1'b1;
    s_id[0] = 32'h11; s_ic[0] = 8'h01; dc(); tick();
    s_id[0] = 32'h22; s_ic[0] = 8'h02; dc(); tick();
    s_fl[0] = 1'b1; s_id[0] = 32'h33; s_ic[0] = 8'h03; dc(); tick();
    s_fl[0] = 1'b0; s_iv[0] = 1'b0; s_ir[0] = 1'b1; dc();
    chk("flush.out_valid", 64'(o_v[0]), 64'd0);
    chk("flush.out_ctrl", 64'(o_c[0]), 64'd0);
    chk("flush.occupancy", 64'(o_occ[0]), 64'd0);
    chk("flush.in_ready", 64'(o_ir[0]), 64'd1);
    tick();
    repeat (3) begin dc(); tick(); end

    // single-entry stage: replace-on-deliver and combinational in_ready
    s_ir[1] = 1'b0; s_iv[1] = 1'b1; s_id[1] = 32'h55; s_ic[1] = 8'h05; dc(); tick();
    s_ir[1] = 1'b1; s_id[1] = 32'h66; s_ic[1] = 8'h06; dc();
    chk("noskid.in_ready_hi", 64'(o_ir[1]), 64'd1);
    tick();
    s_ir[1] = 1'b0; s_id[1] = 32'h77; s_ic[1] = 8'h07; dc();
    chk("noskid.replaced", 64'(o_d[1]), 64'h66);
    chk("noskid.in_ready_lo", 64'(o_ir[1]), 64'd0);
    tick();
    s_iv[1] = 1'b0; s_ir[1] = 1'b1; dc(); tick();

    // 4-bit stall counter saturation, then asynchronous clear
    do_reset();
    s_iv[0] = 1'b1; s_ir[0] = 1'b0; s_id[0] = 32'hAA; s_ic[0] = 8'h0A; dc(); tick();
    s_iv[0] = 1'b0;
    repeat (20) begin dc(); tick(); end
    dc();
    chk("sat.stall_cnt", 64'(o_st[0]), 64'd15);
    nRST = 1'b0;
    #1;
    chk("sat.async_clear", 64'(o_st[0]), 64'd0);
    chk("sat.async_empty", 64'(o_occ[0]), 64'd0);
    do_reset();

    // random traffic on both stages
    for (int c = 0; c < 2000; c++) begin
      for (int d = 0; d < 2; d++) begin
        s_iv[d] = ($urandom_range(0, 3) != 0);
        s_ir[d] = ($urandom_range(0, 2) != 0);
        s_fl[d] = ($urandom_range(0, 63) == 0);
        s_id[d] = $urandom;
        s_ic[d] = 8'($urandom);
      end
      dc(); tick();
    end
    idle();
    repeat (4) begin dc(); tick(); end
    dc();
    chk("rand.drained0", 64'(o_occ[0]), 64'd0);
    chk("rand.drained1", 64'(o_occ[1]), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipeline_stage_buf.md
# pipeline_stage_buf

Parametrised pipeline stage register that replaces the fixed inter-stage latches between CPU pipeline stages. It carries a payload word and a control word between two stages using a valid/ready handshake instead of a global enable. An optional 2-entry skid buffer gives full throughput with a fully registered `in_ready`. It supports synchronous flush and keeps a saturating back-pressure counter for performance monitoring.

## Interface
- `DATA_W`, default 32: payload width. Payload is not cleared on flush or bubble.
- `CTRL_W`, default 8: control width (regWEN, halt, MemtoReg-style bits). Forced to 0 whenever the output is not valid.
- `SKID`, default 1: selects the buffering mode. 1 = 2-entry skid buffer with registered `in_ready`. 0 = single entry with combinational `in_ready`.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous kill of all held entries.
- `in_valid`  in  1  upstream has an entry.
- `in_ready`  out  1  stage can accept an entry this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream control.
- `out_valid`  out  1  an entry is presented downstream.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  DATA_W  head payload.
- `out_ctrl`  out  CTRL_W  head control. Equals 0 when `out_valid`=0.
- `occupancy`  out  2  number of held entries (0..2; max 1 when SKID=0).
- `stall_cnt`  out  CNT_W  cycles with `out_valid`=1 and `out_ready`=0. Saturating.

## Operation
- Accept: `in_valid && in_ready`. Deliver: `out_valid && out_ready`.
- Storage: a main register (the head, which drives the outputs) and a skid register (used only when SKID=1).
- States for SKID=1:
  - EMPTY: `in_ready`=1, `out_valid`=0.
  - ONE: `in_ready`=1, `out_valid`=1.
  - TWO: `in_ready`=0, `out_valid`=1.
- Transitions for SKID=1:
  - EMPTY + accept → ONE; the input is written into main.
  - ONE + accept + deliver → ONE; main is replaced by the input.
  - ONE + accept, no deliver → TWO; the input is written into skid.
  - ONE + deliver, no accept → EMPTY.
  - TWO + deliver → ONE; skid moves to main. No accept is possible in TWO.
- `in_ready` is a function of registered state only (it equals "state ≠ TWO").
- SKID=0:
  - `in_ready` = !full || out_ready (combinational path from `out_ready`).
  - Accept while full + deliver replaces main in the same cycle.
  - Accept while empty fills main.
- Flush: at the next edge, state → EMPTY and `occupancy` → 0.
  - Any entry accepted in the flush cycle is discarded.
  - A deliver in the flush cycle still counts for downstream.
  - Payload registers keep their old values. Control registers are cleared.
- `out_ctrl` = main control when `out_valid`=1, otherwise all zeros. `out_data` holds its last value when empty.
- `stall_cnt` increments by 1 in every cycle where `out_valid && !out_ready`, and saturates at 2^CNT_W−1.
  - It is not cleared by `flush`; it is cleared only by reset.
- Ordering is strict FIFO. No entry is ever duplicated or dropped except by `flush`.

## Timing
- Reset (async, `nRST`=0):
  - state EMPTY, `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `stall_cnt`=0.
  - Skid contents = 0.
  - `in_ready`=1 while in reset for both modes.
- Latency: an entry accepted at edge N appears on the outputs after edge N, visible in cycle N+1. There is no combinational data path from `in_*` to `out_*`.
- Throughput: 1 entry/cycle in both modes when `out_ready`=1 continuously.
- SKID=1: `in_ready` is registered. After `out_ready` rises in state TWO, `in_ready` returns to 1 in the following cycle.
- Flush asserted in cycle N: `out_valid`=0 in cycle N+1. `in_ready`=1 in cycle N+1.
- Reset asserted mid-transfer: all entries are lost immediately, asynchronously. There is no partial update on release.

## Test plan
- Reset, then stream 0x100..0x107 with `out_ready`=1, SKID=1 → outputs appear one cycle later in order, 8 consecutive cycles of `out_valid`, `stall_cnt`=0.
- SKID=1, fill A=0x11 then B=0x22 with `out_ready`=0 → `occupancy`=2 and `in_ready`=0. Raise `out_ready` → A then B delivered on consecutive cycles; `stall_cnt`=2 for the 2-cycle hold.
- Flush in state TWO while `in_valid`=1 with C=0x33 → next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0; C is never delivered.
- SKID=0, full with `out_ready`=1 and new input → `in_ready`=1 in the same cycle and main is replaced. With `out_ready`=0 → `in_ready`=0.
- CNT_W=4: hold `out_valid`=1, `out_ready`=0 for 20 cycles → `stall_cnt` saturates at 15. Assert `nRST`=0 → `stall_cnt`=0 immediately.
- Random valid/ready over 2000 cycles, both SKID values → scoreboard shows in-order, lossless delivery, and `out_ctrl`=0 whenever `out_valid`=0.
